// File: rtl/uart_tx_fifo_param_pkg.sv
// rtl/uart_tx_fifo_param_pkg.sv - shared constants, FSM encoding and parity helper for the UART TX
//
// Purpose : Parity-mode constants, TX FSM state encoding and a parity helper. Kept in a
//           package so a future RX block can share exactly the same definitions.
// Ports   : none (package)

package uart_tx_fifo_param_pkg;

  // Parity mode selector values for the PARITY parameter.
  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 1;
  localparam int PARITY_ODD  = 2;

  // Widest data word any UART block in this family supports.
  localparam int MAX_DATA_BITS = 9;

  // TX FSM states.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_PAR   = 3'd3,
    ST_STOP  = 3'd4
  } tx_state_t;

  // Parity bit to put on the line for a word. The caller zero-extends narrower words,
  // which leaves the XOR reduction unchanged.
  function automatic logic parity_bit(input logic [MAX_DATA_BITS-1:0] i_word,
                                      input int                       i_mode);
    logic w_xor;
    w_xor = ^i_word;
    return (i_mode == PARITY_ODD) ? ~w_xor : w_xor;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - small synchronous FIFO feeding the UART transmitter
//
// Purpose : Power-of-two deep, first-word-fall-through FIFO. A pop and a write in the same
//           cycle are allowed even when full, because the pop frees the slot the write uses.
// Ports   : i_clk    in  1      clock, rising edge
//           i_rst_n  in  1      asynchronous active-low reset, empties the FIFO
//           i_write  in  1      write strobe (ignored when full and not popping)
//           i_data   in  WIDTH  word to store
//           i_pop    in  1      remove the head word (ignored when empty)
//           o_q      out WIDTH  head word, valid while o_empty is low
//           o_empty  out 1      no words stored
//           o_full   out 1      DEPTH words stored

module uart_tx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_write,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_q,
  output logic             o_empty,
  output logic             o_full
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;

  logic w_do_write;
  logic w_do_pop;

  assign o_empty    = (r_count == '0);
  assign o_full     = (r_count == (AW+1)'(DEPTH));
  assign w_do_pop   = i_pop & ~o_empty;
  // A write while full only lands if the head leaves in the same cycle.
  assign w_do_write = i_write & (~o_full | w_do_pop);
  assign o_q        = r_mem[r_rd_ptr];

  // Storage is not reset: contents are meaningless while r_count is zero.
  always_ff @(posedge i_clk) begin
    if (w_do_write) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_write) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_do_write, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_fifo_param.sv
// rtl/uart_tx_fifo_param.sv - parametrised UART transmitter with baud divider and write FIFO
//
// Purpose : Serialises words from a small FIFO as UART frames: start bit, DATA_BITS data bits
//           LSB first, optional parity bit, STOP_BITS stop bits. Bit time is CLKS_PER_BIT
//           system clocks. Back-to-back frames are sent with no idle gap between them.
// Ports   : i_clk     in  1          system clock, rising edge
//           i_rst_n   in  1          asynchronous active-low reset; aborts any frame in flight
//           i_write   in  1          write strobe, accepted when o_full is low
//           i_data    in  DATA_BITS  word to send, sampled on the accepting edge
//           o_full    out 1          a write in this cycle would be dropped
//           o_busy    out 1          FIFO non-empty or a frame is in progress
//           o_uart_tx out 1          serial line, idle high, driven from a register

module uart_tx_fifo_param
  import uart_tx_fifo_param_pkg::*;
#(
  parameter int DATA_BITS    = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_write,
  input  logic [DATA_BITS-1:0] i_data,
  output logic                 o_full,
  output logic                 o_busy,
  output logic                 o_uart_tx
);

  // Illegal parameter sets are rejected at elaboration rather than handled in logic.
  generate
    if (DATA_BITS < 5 || DATA_BITS > MAX_DATA_BITS) begin : g_bad_data_bits
      $error("uart_tx_fifo_param: DATA_BITS must be 5..9");
    end
    if (CLKS_PER_BIT < 2) begin : g_bad_clks_per_bit
      $error("uart_tx_fifo_param: CLKS_PER_BIT must be >= 2");
    end
    if (PARITY < PARITY_NONE || PARITY > PARITY_ODD) begin : g_bad_parity
      $error("uart_tx_fifo_param: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
      $error("uart_tx_fifo_param: STOP_BITS must be 1 or 2");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_fifo_depth
      $error("uart_tx_fifo_param: FIFO_DEPTH must be a power of two >= 2");
    end
  endgenerate

  localparam int DIV_W = $clog2(CLKS_PER_BIT);
  // Bit counter serves both the data bits and the stop bits.
  localparam int CNT_W = $clog2(DATA_BITS + 1);

  tx_state_t            r_state;
  tx_state_t            w_next_state;
  logic [DIV_W-1:0]     r_div;
  logic [CNT_W-1:0]     r_bit_cnt;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_par;
  logic                 r_tx;
  logic                 w_tx_next;

  logic                 w_tick;
  logic                 w_last_data;
  logic                 w_last_stop;
  logic                 w_pop;
  logic                 w_state_change;

  logic [DATA_BITS-1:0] w_fifo_q;
  logic                 w_fifo_empty;
  logic                 w_fifo_full;

  uart_tx_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_write (i_write),
    .i_data  (i_data),
    .i_pop   (w_pop),
    .o_q     (w_fifo_q),
    .o_empty (w_fifo_empty),
    .o_full  (w_fifo_full)
  );

  assign w_tick         = (r_div == DIV_W'(CLKS_PER_BIT - 1));
  assign w_last_data    = (r_bit_cnt == CNT_W'(DATA_BITS - 1));
  assign w_last_stop    = (r_bit_cnt == CNT_W'(STOP_BITS - 1));
  assign w_state_change = (w_next_state != r_state);

  // A pop this cycle frees a slot, so the producer is not told the FIFO is full.
  assign o_full    = w_fifo_full & ~w_pop;
  assign o_busy    = (r_state != ST_IDLE) | ~w_fifo_empty;
  assign o_uart_tx = r_tx;

  // FSM: state register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // FSM: next-state logic.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_pop) begin
          w_next_state = ST_START;
        end
      end
      ST_START: begin
        if (w_tick) begin
          w_next_state = ST_DATA;
        end
      end
      ST_DATA: begin
        if (w_tick && w_last_data) begin
          w_next_state = (PARITY != PARITY_NONE) ? ST_PAR : ST_STOP;
        end
      end
      ST_PAR: begin
        if (w_tick) begin
          w_next_state = ST_STOP;
        end
      end
      ST_STOP: begin
        // Chain straight into the next start bit when more data is waiting.
        if (w_tick && w_last_stop) begin
          w_next_state = w_pop ? ST_START : ST_IDLE;
        end
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  // FSM: outputs (FIFO pop and the next line level).
  always_comb begin
    w_pop     = 1'b0;
    w_tx_next = 1'b1;
    case (r_state)
      ST_IDLE: begin
        w_pop = ~w_fifo_empty;
      end
      ST_START: begin
        w_tx_next = 1'b0;
      end
      ST_DATA: begin
        w_tx_next = r_shift[0];
      end
      ST_PAR: begin
        w_tx_next = r_par;
      end
      ST_STOP: begin
        w_pop = w_tick & w_last_stop & ~w_fifo_empty;
      end
      default: begin
        w_pop     = 1'b0;
        w_tx_next = 1'b1;
      end
    endcase
  end

  // Datapath: divider, bit counter, shifter, parity and the registered line.
  // The line register lags the state by one clock, which keeps it glitch-free and gives
  // every bit exactly CLKS_PER_BIT cycles on the pin.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_div     <= '0;
      r_bit_cnt <= '0;
      r_shift   <= '0;
      r_par     <= 1'b0;
      r_tx      <= 1'b1;
    end else begin
      r_tx <= w_tx_next;

      // Divider restarts on every state entry and rests at zero while idle.
      if (w_state_change || w_tick || r_state == ST_IDLE) begin
        r_div <= '0;
      end else begin
        r_div <= r_div + 1'b1;
      end

      if (w_state_change) begin
        r_bit_cnt <= '0;
      end else if (w_tick && (r_state == ST_DATA || r_state == ST_STOP)) begin
        r_bit_cnt <= r_bit_cnt + 1'b1;
      end

      if (w_pop) begin
        r_shift <= w_fifo_q;
        r_par   <= parity_bit(MAX_DATA_BITS'(w_fifo_q), PARITY);
      end else if (w_tick && r_state == ST_DATA) begin
        r_shift <= {1'b0, r_shift[DATA_BITS-1:1]};
      end
    end
  end

endmodule
